triangle_setup: RTL and testbench

TRIANGLE_SETUP -- requirements
Module: triangle_setup

---
 rtl/gpu_pkg.sv | 57 +++++
 rtl/recip_div.sv | 79 +++++++
 rtl/triangle_setup.sv | 257 +++++++++++++++++++++++++
 tb/tb_triangle_setup.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants, widths and the setup FSM state type for the
// triangle setup slice (triangle_setup, recip_div).
// No ports.
package gpu_pkg;

  localparam int SCREEN_W       = 320;
  localparam int SCREEN_H       = 240;
  localparam int INV_AREA_SHIFT = 24;

  localparam int X_W    = 9;   // screen x
  localparam int Y_W    = 8;   // screen y
  localparam int Z_W    = 16;
  localparam int COL_W  = 8;
  localparam int AB_W   = 10;  // edge a/b coefficients, signed
  localparam int C_W    = 18;  // edge c coefficients, signed
  localparam int PROD_W = 17;  // unsigned x*y product
  localparam int AREA_W = 19;  // twice the signed area
  localparam int INV_W  = 32;

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE,
    S_SUM,
    S_CHECK,
    S_DIV,
    S_START,
    S_WAIT
  } setup_state_t;

  function automatic logic [X_W-1:0] min3_x(input logic [X_W-1:0] a, b, c);
    logic [X_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [X_W-1:0] max3_x(input logic [X_W-1:0] a, b, c);
    logic [X_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [Y_W-1:0] min3_y(input logic [Y_W-1:0] a, b, c);
    logic [Y_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [Y_W-1:0] max3_y(input logic [Y_W-1:0] a, b, c);
    logic [Y_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/recip_div.sv
// recip_div: restoring divider computing floor(2^INV_AREA_SHIFT / divisor),
// one quotient bit per clock (INV_AREA_SHIFT+1 cycles).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      load divisor and begin (ignored while busy)
//   divisor    19-bit unsigned, must be non-zero
//   done       one-cycle pulse, quotient valid from this cycle on
//   quotient   32-bit result, held until the next start
module recip_div
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AREA_W-1:0] divisor,
  output logic              done,
  output logic [INV_W-1:0]  quotient
);

  localparam int QW = INV_AREA_SHIFT + 1;

  logic              r_busy;
  logic              r_done;
  logic [4:0]        r_cnt;
  logic [AREA_W-1:0] r_rem;
  logic [AREA_W-1:0] r_dvs;
  logic [QW-1:0]     r_quo;
  logic [QW-1:0]     r_den;

  logic [AREA_W:0]   w_trial;
  logic              w_take;

  // Remainder stays below the divisor, so one extra bit holds the trial.
  assign w_trial = {r_rem, r_den[QW-1]};
  assign w_take  = (w_trial >= {1'b0, r_dvs});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (start) begin
          r_busy <= 1'b1;
          r_cnt  <= 5'(INV_AREA_SHIFT);
          r_rem  <= '0;
          r_quo  <= '0;
          r_den  <= QW'(1) << INV_AREA_SHIFT;
          r_dvs  <= divisor;
        end
      end else begin
        r_den <= {r_den[QW-2:0], 1'b0};
        if (w_take) begin
          r_rem <= AREA_W'(w_trial - {1'b0, r_dvs});
          r_quo <= {r_quo[QW-2:0], 1'b1};
        end else begin
          r_rem <= w_trial[AREA_W-1:0];
          r_quo <= {r_quo[QW-2:0], 1'b0};
        end
        if (r_cnt == 5'd0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 5'd1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = INV_W'(r_quo);

endmodule

// File: rtl/triangle_setup.sv
// triangle_setup: captures a screen-space triangle, derives edge equation
// coefficients, a clamped bounding box and 2^24/(2*area), then hands the
// result to the rasterizer with a start/done handshake. Degenerate and
// fully off-screen triangles are dropped with a tri_culled pulse.
// Build option: BACKFACE_CULL_EN -- when defined, negative-area (clockwise)
// triangles are culled instead of being winding-normalised.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tri_valid / tri_ready       upstream handshake
//   x1..x3, y1..y3              vertex coordinates (9 / 8 bit unsigned)
//   z1..z3, color               passthrough, output on o_z1..o_z3, o_color
//   a1,b1,a2,b2,a3,b3 / c1..c3  edge coefficients (10 / 18 bit signed)
//   bbxi,bbxf,bbyi,bbyf         bounding box, max side clamped to screen
//   inv_area                    floor(2^24 / |area2|)
//   rasterizer_start/_done      downstream handshake
//   tri_culled                  one-cycle pulse per dropped triangle
//
// state   | meaning
// IDLE    | waiting for a triangle (tri_ready high from 2nd cycle on)
// EDGE    | a/b differences, c-term products, bbox min/max
// SUM     | c coefficients and twice the signed area
// CHECK   | cull decision, winding fix-up, publish outputs
// DIV     | reciprocal of |area2| in progress
// START   | rasterizer_start pulse
// WAIT    | waiting for rasterizer_done (first cycle ignored)
module triangle_setup
  import gpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tri_valid,
  output logic                   tri_ready,
  input  logic [X_W-1:0]         x1,
  input  logic [X_W-1:0]         x2,
  input  logic [X_W-1:0]         x3,
  input  logic [Y_W-1:0]         y1,
  input  logic [Y_W-1:0]         y2,
  input  logic [Y_W-1:0]         y3,
  input  logic [Z_W-1:0]         z1,
  input  logic [Z_W-1:0]         z2,
  input  logic [Z_W-1:0]         z3,
  input  logic [COL_W-1:0]       color,
  output logic [Z_W-1:0]         o_z1,
  output logic [Z_W-1:0]         o_z2,
  output logic [Z_W-1:0]         o_z3,
  output logic [COL_W-1:0]       o_color,
  output logic signed [AB_W-1:0] a1,
  output logic signed [AB_W-1:0] b1,
  output logic signed [AB_W-1:0] a2,
  output logic signed [AB_W-1:0] b2,
  output logic signed [AB_W-1:0] a3,
  output logic signed [AB_W-1:0] b3,
  output logic signed [C_W-1:0]  c1,
  output logic signed [C_W-1:0]  c2,
  output logic signed [C_W-1:0]  c3,
  output logic [X_W-1:0]         bbxi,
  output logic [X_W-1:0]         bbxf,
  output logic [Y_W-1:0]         bbyi,
  output logic [Y_W-1:0]         bbyf,
  output logic [INV_W-1:0]       inv_area,
  output logic                   rasterizer_start,
  input  logic                   rasterizer_done,
  output logic                   tri_culled
);

  setup_state_t r_state;

  // working registers
  logic [X_W-1:0]         r_x1, r_x2, r_x3;
  logic [Y_W-1:0]         r_y1, r_y2, r_y3;
  logic signed [AB_W-1:0] r_a [3];
  logic signed [AB_W-1:0] r_b [3];
  logic signed [C_W-1:0]  r_c [3];
  logic [PROD_W-1:0]      r_p [6];
  logic [X_W-1:0]         r_minx, r_maxx;
  logic [Y_W-1:0]         r_miny, r_maxy;
  logic signed [AREA_W-1:0] r_area2;

  // published registers
  logic                   r_tri_ready, r_start, r_culled, r_wait_first;
  logic signed [AB_W-1:0] r_oa [3];
  logic signed [AB_W-1:0] r_ob [3];
  logic signed [C_W-1:0]  r_oc [3];
  logic [X_W-1:0]         r_bbxi, r_bbxf;
  logic [Y_W-1:0]         r_bbyi, r_bbyf;
  logic [INV_W-1:0]       r_inv;
  logic [Z_W-1:0]         r_z [3];
  logic [COL_W-1:0]       r_color;

  logic signed [C_W-1:0]    w_c [3];
  logic signed [AREA_W-1:0] w_a1e, w_b1e, w_x1e, w_y1e, w_c1e, w_area2;
  logic                     w_neg, w_cull, w_div_start, w_div_done;
  logic [AREA_W-1:0]        w_abs;
  logic [INV_W-1:0]         w_quot;

  always_comb begin
    w_c[0] = $signed({1'b0, r_p[0]}) - $signed({1'b0, r_p[1]});
    w_c[1] = $signed({1'b0, r_p[2]}) - $signed({1'b0, r_p[3]});
    w_c[2] = $signed({1'b0, r_p[4]}) - $signed({1'b0, r_p[5]});
  end

  // Twice the area fits in 19 signed bits, so modular 19-bit arithmetic
  // on the partial products gives the exact result.
  assign w_a1e   = {{(AREA_W-AB_W){r_a[0][AB_W-1]}}, r_a[0]};
  assign w_b1e   = {{(AREA_W-AB_W){r_b[0][AB_W-1]}}, r_b[0]};
  assign w_c1e   = {{(AREA_W-C_W){w_c[0][C_W-1]}}, w_c[0]};
  assign w_x1e   = {{(AREA_W-X_W){1'b0}}, r_x1};
  assign w_y1e   = {{(AREA_W-Y_W){1'b0}}, r_y1};
  assign w_area2 = w_a1e * w_x1e + w_b1e * w_y1e + w_c1e;

  assign w_neg = r_area2[AREA_W-1];
  assign w_abs = w_neg ? -r_area2 : r_area2;

`ifdef BACKFACE_CULL_EN
  assign w_cull = (r_area2 == '0) || w_neg || (r_minx > X_MAX) || (r_miny > Y_MAX);
`else
  assign w_cull = (r_area2 == '0) || (r_minx > X_MAX) || (r_miny > Y_MAX);
`endif

  // Launching the divider straight from CHECK keeps START at capture+29.
  assign w_div_start = (r_state == S_CHECK) && !w_cull;

  recip_div u_recip_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .divisor  (w_abs),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (tri_valid && r_tri_ready) begin
          r_x1 <= x1; r_x2 <= x2; r_x3 <= x3;
          r_y1 <= y1; r_y2 <= y2; r_y3 <= y3;
        end
      end
      S_EDGE: begin
        r_a[0] <= $signed({2'b00, r_y2}) - $signed({2'b00, r_y3});
        r_a[1] <= $signed({2'b00, r_y3}) - $signed({2'b00, r_y1});
        r_a[2] <= $signed({2'b00, r_y1}) - $signed({2'b00, r_y2});
        r_b[0] <= $signed({1'b0, r_x3}) - $signed({1'b0, r_x2});
        r_b[1] <= $signed({1'b0, r_x1}) - $signed({1'b0, r_x3});
        r_b[2] <= $signed({1'b0, r_x2}) - $signed({1'b0, r_x1});
        r_p[0] <= PROD_W'(r_x2) * PROD_W'(r_y3);
        r_p[1] <= PROD_W'(r_x3) * PROD_W'(r_y2);
        r_p[2] <= PROD_W'(r_x3) * PROD_W'(r_y1);
        r_p[3] <= PROD_W'(r_x1) * PROD_W'(r_y3);
        r_p[4] <= PROD_W'(r_x1) * PROD_W'(r_y2);
        r_p[5] <= PROD_W'(r_x2) * PROD_W'(r_y1);
        r_minx <= min3_x(r_x1, r_x2, r_x3);
        r_maxx <= max3_x(r_x1, r_x2, r_x3);
        r_miny <= min3_y(r_y1, r_y2, r_y3);
        r_maxy <= max3_y(r_y1, r_y2, r_y3);
      end
      S_SUM: begin
        for (int i = 0; i < 3; i++) r_c[i] <= w_c[i];
        r_area2 <= w_area2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tri_ready  <= 1'b1;
      r_start      <= 1'b0;
      r_culled     <= 1'b0;
      r_wait_first <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_oa[i] <= '0;
        r_ob[i] <= '0;
        r_oc[i] <= '0;
        r_z[i]  <= '0;
      end
      r_color <= '0;
      r_bbxi  <= '0;
      r_bbxf  <= '0;
      r_bbyi  <= '0;
      r_bbyf  <= '0;
      r_inv   <= '0;
    end else begin
      r_culled <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // tri_ready rises one cycle after re-entering IDLE
          if (tri_valid && r_tri_ready) begin
            r_z[0]      <= z1;
            r_z[1]      <= z2;
            r_z[2]      <= z3;
            r_color     <= color;
            r_tri_ready <= 1'b0;
            r_state     <= S_EDGE;
          end else begin
            r_tri_ready <= 1'b1;
          end
        end
        S_EDGE:  r_state <= S_SUM;
        S_SUM:   r_state <= S_CHECK;
        S_CHECK: begin
          if (w_cull) begin
            r_culled <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            for (int i = 0; i < 3; i++) begin
              r_oa[i] <= w_neg ? -r_a[i] : r_a[i];
              r_ob[i] <= w_neg ? -r_b[i] : r_b[i];
              r_oc[i] <= w_neg ? -r_c[i] : r_c[i];
            end
            r_bbxi  <= r_minx;
            r_bbyi  <= r_miny;
            r_bbxf  <= (r_maxx > X_MAX) ? X_MAX : r_maxx;
            r_bbyf  <= (r_maxy > Y_MAX) ? Y_MAX : r_maxy;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_inv   <= w_quot;
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_start      <= 1'b0;
          r_wait_first <= 1'b1;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_first) r_wait_first <= 1'b0;
          else if (rasterizer_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tri_ready        = r_tri_ready;
  assign rasterizer_start = r_start;
  assign tri_culled       = r_culled;
  assign a1 = r_oa[0]; assign b1 = r_ob[0]; assign c1 = r_oc[0];
  assign a2 = r_oa[1]; assign b2 = r_ob[1]; assign c2 = r_oc[1];
  assign a3 = r_oa[2]; assign b3 = r_ob[2]; assign c3 = r_oc[2];
  assign bbxi     = r_bbxi;
  assign bbxf     = r_bbxf;
  assign bbyi     = r_bbyi;
  assign bbyf     = r_bbyf;
  assign inv_area = r_inv;
  assign o_z1     = r_z[0];
  assign o_z2     = r_z[1];
  assign o_z3     = r_z[2];
  assign o_color  = r_color;

endmodule

// File: tb/tb_triangle_setup.sv
// tb_triangle_setup: directed vectors with hand-computed expectations for
// triangle_setup. Honours BACKFACE_CULL_EN for the clockwise-triangle case.
module tb_triangle_setup;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tri_valid = 1'b0;
  logic tri_ready;
  logic [8:0] x1 = '0, x2 = '0, x3 = '0;
  logic [7:0] y1 = '0, y2 = '0, y3 = '0;
  logic [15:0] z1 = 16'h1234, z2 = 16'hBEEF, z3 = 16'h0F0F;
  logic [7:0] color = 8'hA5;
  logic [15:0] o_z1, o_z2, o_z3;
  logic [7:0] o_color;
  logic signed [9:0] a1, b1, a2, b2, a3, b3;
  logic signed [17:0] c1, c2, c3;
  logic [8:0] bbxi, bbxf;
  logic [7:0] bbyi, bbyf;
  logic [31:0] inv_area;
  logic rasterizer_start;
  logic rasterizer_done = 1'b0;
  logic tri_culled;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt, start_cyc, cull_cnt, cull_cyc;
  int n;

  triangle_setup dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3),
    .z1(z1), .z2(z2), .z3(z3), .color(color),
    .o_z1(o_z1), .o_z2(o_z2), .o_z3(o_z3), .o_color(o_color),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .inv_area(inv_area),
    .rasterizer_start(rasterizer_start), .rasterizer_done(rasterizer_done),
    .tri_culled(tri_culled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rasterizer_start) begin start_cnt++; start_cyc = cyc; end
    if (tri_culled)       begin cull_cnt++;  cull_cyc  = cyc; end
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    start_cnt = 0; start_cyc = -1; cull_cnt = 0; cull_cyc = -1;
  endtask

  // Offer one triangle; returns the capture cycle index N.
  task automatic send(input int ax1, ay1, ax2, ay2, ax3, ay3, output int cap);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!tri_ready && guard < 100) begin @(negedge clk); guard++; end
    chk("tri_ready_before_send", tri_ready, 1);
    x1 = ax1[8:0]; y1 = ay1[7:0];
    x2 = ax2[8:0]; y2 = ay2[7:0];
    x3 = ax3[8:0]; y3 = ay3[7:0];
    tri_valid = 1'b1;
    @(negedge clk);
    cap = cyc;
    tri_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tri_ready", tri_ready, 1);
    chk("rst_start", rasterizer_start, 0);
    chk("rst_culled", tri_culled, 0);
    chk("rst_a1", a1, 0);
    chk("rst_c3", c3, 0);
    chk("rst_bbxf", bbxf, 0);
    chk("rst_inv", inv_area, 0);
    chk("rst_z1", o_z1, 0);
    chk("rst_color", o_color, 0);
    rst = 1'b0;

    // Counter-clockwise reference triangle; done held low to park in WAIT.
    clear_mon();
    send(10, 10, 20, 10, 10, 20, n);
    wait_until(n + 35);
    chk("t1_start_cnt", start_cnt, 1);
    chk("t1_start_cyc", start_cyc, n + 29);
    chk("t1_cull_cnt", cull_cnt, 0);
    chk("t1_parked_in_wait", tri_ready, 0);
    rasterizer_done = 1'b1;
    wait_until(n + 37);
    chk("t1_back_to_idle", tri_ready, 1);
    chk("t1_a1", a1, -10); chk("t1_b1", b1, -10); chk("t1_c1", c1, 300);
    chk("t1_a2", a2, 10);  chk("t1_b2", b2, 0);   chk("t1_c2", c2, -100);
    chk("t1_a3", a3, 0);   chk("t1_b3", b3, 10);  chk("t1_c3", c3, -100);
    chk("t1_bbxi", bbxi, 10); chk("t1_bbxf", bbxf, 20);
    chk("t1_bbyi", bbyi, 10); chk("t1_bbyf", bbyf, 20);
    chk("t1_inv", inv_area, 167772);
    chk("t1_z1", o_z1, 16'h1234); chk("t1_z2", o_z2, 16'hBEEF);
    chk("t1_z3", o_z3, 16'h0F0F); chk("t1_color", o_color, 8'hA5);

    // Same triangle, clockwise; done held high since before START.
    clear_mon();
    send(10, 10, 10, 20, 20, 10, n);
`ifdef BACKFACE_CULL_EN
    wait_until(n + 35);
    chk("t2_cull_cnt", cull_cnt, 1);
    chk("t2_cull_cyc", cull_cyc, n + 3);
    chk("t2_start_cnt", start_cnt, 0);
    chk("t2_a1_unchanged", a1, -10);
`else
    wait_until(n + 32);
    chk("t2_first_wait_ignored", tri_ready, 0);
    wait_until(n + 33);
    chk("t2_second_wait_taken", tri_ready, 1);
    chk("t2_start_cyc", start_cyc, n + 29);
    chk("t2_cull_cnt", cull_cnt, 0);
    chk("t2_a1", a1, -10); chk("t2_b1", b1, -10); chk("t2_c1", c1, 300);
    chk("t2_a2", a2, 0);   chk("t2_b2", b2, 10);  chk("t2_c2", c2, -100);
    chk("t2_a3", a3, 10);  chk("t2_b3", b3, 0);   chk("t2_c3", c3, -100);
    chk("t2_inv", inv_area, 167772);
`endif

    // Collinear -> zero area.
    clear_mon();
    send(0, 0, 5, 5, 10, 10, n);
    wait_until(n + 3);
    chk("col_culled_pulse", tri_culled, 1);
    chk("col_ready_n3", tri_ready, 0);
    wait_until(n + 4);
    chk("col_ready_n4", tri_ready, 1);
    chk("col_culled_once", tri_culled, 0);
    wait_until(n + 35);
    chk("col_no_start", start_cnt, 0);

    // Max x and max y beyond the screen are clamped.
    clear_mon();
    send(100, 50, 330, 60, 120, 250, n);
    wait_until(n + 34);
    chk("clamp_start_cyc", start_cyc, n + 29);
    chk("clamp_bbxi", bbxi, 100); chk("clamp_bbxf", bbxf, 319);
    chk("clamp_bbyi", bbyi, 50);  chk("clamp_bbyf", bbyf, 239);
    chk("clamp_a1", a1, -190); chk("clamp_b1", b1, -210); chk("clamp_c1", c1, 75300);
    chk("clamp_a2", a2, 200);  chk("clamp_b2", b2, -20);  chk("clamp_c2", c2, -19000);
    chk("clamp_a3", a3, -10);  chk("clamp_b3", b3, 230);  chk("clamp_c3", c3, -10500);
    chk("clamp_inv", inv_area, 366);

    // Entirely right of the screen.
    clear_mon();
    send(400, 10, 420, 10, 400, 30, n);
    wait_until(n + 35);
    chk("offx_cull_cyc", cull_cyc, n + 3);
    chk("offx_no_start", start_cnt, 0);

    // Entirely below the screen.
    clear_mon();
    send(10, 240, 50, 240, 10, 250, n);
    wait_until(n + 35);
    chk("offy_cull_cyc", cull_cyc, n + 3);
    chk("offy_no_start", start_cnt, 0);

    // Reset while dividing, then a fresh triangle.
    clear_mon();
    send(10, 10, 20, 10, 10, 20, n);
    wait_until(n + 12);
    rst = 1'b1;
    wait_until(n + 13);
    chk("mid_rst_ready", tri_ready, 1);
    chk("mid_rst_start", rasterizer_start, 0);
    chk("mid_rst_a1", a1, 0);
    chk("mid_rst_c1", c1, 0);
    chk("mid_rst_bbxf", bbxf, 0);
    chk("mid_rst_inv", inv_area, 0);
    chk("mid_rst_z1", o_z1, 0);
    rst = 1'b0;
    clear_mon();
    send(100, 50, 330, 60, 120, 250, n);
    wait_until(n + 34);
    chk("post_rst_start_cnt", start_cnt, 1);
    chk("post_rst_start_cyc", start_cyc, n + 29);
    chk("post_rst_inv", inv_area, 366);
    chk("post_rst_a1", a1, -190);
    chk("post_rst_z2", o_z2, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
